// File: rtl/oled_pkg.sv
// Shared constants, FSM state type and SPI frame lengths
// for the SSD1331 (PmodOLEDrgb) pixel streamer.
package oled_pkg;

  localparam int OLED_W    = 96;
  localparam int OLED_H    = 64;
  localparam int OLED_NPIX = OLED_W * OLED_H;

  localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;

  localparam int BYTE_CYCLES = 18;
  localparam int PIX_CYCLES  = 32;

  typedef enum logic [2:0] {
    PWR,
    RST_LO,
    RST_HI,
    INIT,
    VCC,
    DON,
    PRIME,
    STREAM
  } oled_state_e;

endpackage

// File: rtl/oled_spi_stream_if.sv
// Pixel-source handshake plus PmodOLEDrgb pins.
// master = streamer, slave = pixel source / panel side.
interface oled_spi_stream_if;

  logic [15:0] pixel_data;
  logic [12:0] pixel_index;
  logic        sample_pixel;
  logic        frame_begin;
  logic        sending_pixels;
  logic        cs;
  logic        sdin;
  logic        sclk;
  logic        d_cn;
  logic        resn;
  logic        vccen;
  logic        pmoden;

  modport master (
    input  pixel_data,
    output pixel_index, sample_pixel, frame_begin,
    output sending_pixels, cs, sdin, sclk,
    output d_cn, resn, vccen, pmoden
  );

  modport slave (
    output pixel_data,
    input  pixel_index, sample_pixel, frame_begin,
    input  sending_pixels, cs, sdin, sclk,
    input  d_cn, resn, vccen, pmoden
  );

endinterface

// File: rtl/oled_init_rom.sv
// SSD1331 init command sequence (display off, RGB565 remap,
// contrast, timing, precharge). Unused addresses read NOP.
module oled_init_rom
  import oled_pkg::*;
(
  input  logic [5:0] addr_i,
  output logic [7:0] data_o
);

  always_comb begin
    data_o = 8'hE3;
    case (addr_i)
      6'd0:  data_o = CMD_DISPLAY_OFF;
      6'd1:  data_o = 8'hA0;
      6'd2:  data_o = 8'h72;
      6'd3:  data_o = 8'hA1;
      6'd4:  data_o = 8'h00;
      6'd5:  data_o = 8'hA2;
      6'd6:  data_o = 8'h00;
      6'd7:  data_o = 8'hA4;
      6'd8:  data_o = 8'hA8;
      6'd9:  data_o = 8'h3F;
      6'd10: data_o = 8'hAD;
      6'd11: data_o = 8'h8E;
      6'd12: data_o = 8'hB0;
      6'd13: data_o = 8'h0B;
      6'd14: data_o = 8'hB1;
      6'd15: data_o = 8'h31;
      6'd16: data_o = 8'hB3;
      6'd17: data_o = 8'hF0;
      6'd18: data_o = 8'h8A;
      6'd19: data_o = 8'h64;
      6'd20: data_o = 8'h8B;
      6'd21: data_o = 8'h78;
      6'd22: data_o = 8'h8C;
      6'd23: data_o = 8'h64;
      6'd24: data_o = 8'hBB;
      6'd25: data_o = 8'h3A;
      6'd26: data_o = 8'hBE;
      6'd27: data_o = 8'h3E;
      6'd28: data_o = 8'h87;
      6'd29: data_o = 8'h06;
      6'd30: data_o = 8'h81;
      6'd31: data_o = 8'h91;
      6'd32: data_o = 8'h82;
      6'd33: data_o = 8'h50;
      6'd34: data_o = 8'h83;
      6'd35: data_o = 8'h7D;
      6'd36: data_o = 8'hB9;
      6'd37: data_o = 8'h2E;
      default: data_o = 8'hE3;
    endcase
  end

endmodule

// File: rtl/oled_spi_stream.sv
// SSD1331 power-up, init and continuous RGB565 pixel streamer.
// OLED_TEST_PATTERN_EN: latch an internal x/y colour ramp.
module oled_spi_stream
  import oled_pkg::*;
#(
  parameter int RST_CYCLES = 20,
  parameter int PWR_WAIT   = 125000,
  parameter int VCC_WAIT   = 625000,
  parameter int INIT_LEN   = 38,
  parameter int NPIX       = OLED_NPIX
) (
  input logic my_clk_6p25m,
  input logic oled_reset,
  oled_spi_stream_if.master bus
);

  localparam int W1   = PWR_WAIT > VCC_WAIT ? PWR_WAIT : VCC_WAIT;
  localparam int WMAX = W1 > RST_CYCLES ? W1 : RST_CYCLES;
  localparam int CW   = $clog2(WMAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t        PWR_END   = cnt_t'(PWR_WAIT);
  localparam cnt_t        RST_END   = cnt_t'(RST_CYCLES - 1);
  localparam cnt_t        VCC_END   = cnt_t'(VCC_WAIT - 1);
  localparam logic [5:0]  INIT_LAST = 6'(INIT_LEN - 1);
  localparam logic [12:0] PIX_LAST  = 13'(NPIX - 1);
  localparam logic [4:0]  BYTE_LAST = 5'(BYTE_CYCLES - 1);
  localparam logic [4:0]  SLOT_LAST = 5'(PIX_CYCLES - 1);

  oled_state_e state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [4:0]  k_q, k_d;
  logic [5:0]  byte_q, byte_d;
  logic [12:0] pix_q, pix_d;
  logic [15:0] shreg_q, shreg_d;
  logic        latch;

  logic        cs_q, cs_d, sdin_q, sdin_d, sclk_q, sclk_d;
  logic        dcn_q, dcn_d, resn_q, resn_d;
  logic        vccen_q, vccen_d, pmoden_q, pmoden_d;
  logic        samp_q, samp_d, fb_q, fb_d, send_q, send_d;
  logic [12:0] idx_q, idx_d;

  logic [7:0]  rom_byte;
  logic [7:0]  cmd;
  logic [15:0] colour;

`ifdef OLED_TEST_PATTERN_EN
  function automatic logic [15:0] pattern(input logic [12:0] idx);
    logic [12:0] y, x;
    y = idx / 13'(OLED_W);
    x = idx - y * 13'(OLED_W);
    return {x[6:2], y[5:0], 5'b0};
  endfunction

  logic unused_pix;
  assign unused_pix = ^bus.pixel_data;
  assign colour     = pattern(idx_q);
`else
  assign colour = bus.pixel_data;
`endif

  oled_init_rom u_rom (
    .addr_i (byte_d),
    .data_o (rom_byte)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    byte_d  = byte_q;
    pix_d   = pix_q;
    shreg_d = shreg_q;
    latch   = 1'b0;
    unique case (state_q)
      PWR: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == PWR_END) begin
          state_d = RST_LO;
          cnt_d   = '0;
        end
      end
      RST_LO, RST_HI: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == RST_END) begin
          state_d = (state_q == RST_LO) ? RST_HI : INIT;
          cnt_d   = '0;
          k_d     = '0;
          byte_d  = '0;
        end
      end
      INIT: begin
        k_d = k_q + 5'd1;
        if (k_q == BYTE_LAST) begin
          k_d = '0;
          if (byte_q == INIT_LAST) state_d = VCC;
          else byte_d = byte_q + 6'd1;
        end
      end
      VCC: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == VCC_END) begin
          state_d = DON;
          cnt_d   = '0;
          k_d     = '0;
        end
      end
      DON: begin
        k_d = k_q + 5'd1;
        if (k_q == BYTE_LAST) begin
          state_d = PRIME;
          k_d     = '0;
        end
      end
      PRIME: begin
        k_d = k_q + 5'd1;
        if (k_q == SLOT_LAST) begin
          state_d = STREAM;
          pix_d   = '0;
          latch   = 1'b1;
        end
      end
      STREAM: begin
        k_d = k_q + 5'd1;
        if (k_q == SLOT_LAST) begin
          latch = 1'b1;
          pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + 13'd1;
        end
      end
      default: state_d = PWR;
    endcase
    if (latch) shreg_d = colour;
  end

  // Outputs are registered from the next state so pins are glitch-free
  always_comb begin
    cs_d     = 1'b1;
    sdin_d   = 1'b0;
    sclk_d   = 1'b1;
    dcn_d    = 1'b0;
    resn_d   = 1'b1;
    vccen_d  = 1'b0;
    pmoden_d = 1'b1;
    idx_d    = '0;
    samp_d   = 1'b0;
    fb_d     = 1'b0;
    send_d   = 1'b0;
    cmd      = (state_d == DON) ? CMD_DISPLAY_ON : rom_byte;
    unique case (state_d)
      PWR, RST_HI: ;
      RST_LO: resn_d = 1'b0;
      INIT, DON: begin
        vccen_d = (state_d == DON);
        if (k_d < 5'd16) begin
          cs_d   = 1'b0;
          sclk_d = k_d[0];
          sdin_d = cmd[3'd7 - k_d[3:1]];
        end
      end
      VCC: vccen_d = 1'b1;
      PRIME: begin
        vccen_d = 1'b1;
        samp_d  = (k_d == SLOT_LAST);
      end
      STREAM: begin
        vccen_d = 1'b1;
        cs_d    = 1'b0;
        dcn_d   = 1'b1;
        sclk_d  = k_d[0];
        sdin_d  = shreg_d[4'd15 - k_d[4:1]];
        idx_d   = (pix_d == PIX_LAST) ? '0 : pix_d + 13'd1;
        samp_d  = (k_d == SLOT_LAST);
        fb_d    = (k_d == 5'd0) && (pix_d == '0);
        send_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge my_clk_6p25m) begin
    if (oled_reset) begin
      state_q  <= PWR;
      cnt_q    <= '0;
      k_q      <= '0;
      byte_q   <= '0;
      pix_q    <= '0;
      shreg_q  <= '0;
      cs_q     <= 1'b1;
      sdin_q   <= 1'b0;
      sclk_q   <= 1'b1;
      dcn_q    <= 1'b0;
      resn_q   <= 1'b1;
      vccen_q  <= 1'b0;
      pmoden_q <= 1'b0;
      idx_q    <= '0;
      samp_q   <= 1'b0;
      fb_q     <= 1'b0;
      send_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      byte_q   <= byte_d;
      pix_q    <= pix_d;
      shreg_q  <= shreg_d;
      cs_q     <= cs_d;
      sdin_q   <= sdin_d;
      sclk_q   <= sclk_d;
      dcn_q    <= dcn_d;
      resn_q   <= resn_d;
      vccen_q  <= vccen_d;
      pmoden_q <= pmoden_d;
      idx_q    <= idx_d;
      samp_q   <= samp_d;
      fb_q     <= fb_d;
      send_q   <= send_d;
    end
  end

  assign bus.cs             = cs_q;
  assign bus.sdin           = sdin_q;
  assign bus.sclk           = sclk_q;
  assign bus.d_cn           = dcn_q;
  assign bus.resn           = resn_q;
  assign bus.vccen          = vccen_q;
  assign bus.pmoden         = pmoden_q;
  assign bus.pixel_index    = idx_q;
  assign bus.sample_pixel   = samp_q;
  assign bus.frame_begin    = fb_q;
  assign bus.sending_pixels = send_q;

endmodule

// File: doc/oled_spi_stream.md
Name: oled_spi_stream

Overview:
- SPI transmitter that drives the PmodOLEDrgb (SSD1331, 96x64, RGB565) from a pixel-colour source such as the quiz-mode renderers.
- Sequences panel power-up and init commands, then streams pixels continuously.
- Publishes pixel_index one slot ahead and latches the returned 16-bit pixel_data, MSB first.
- One instance per panel: P1 and P2 each get their own.

Parameters:
- RST_CYCLES, 20: cycles resn is held low, and the settle wait after its release.
- PWR_WAIT, 125000: cycles after pmoden=1 before reset (20 ms at 6.25 MHz).
- VCC_WAIT, 625000: cycles after vccen=1 before display-on (100 ms).
- INIT_LEN, 38: number of init command bytes in oled_init_rom.

Ports:
- my_clk_6p25m  in  1  sole clock, 6.25 MHz.
- oled_reset  in  1  synchronous reset, active-high.
- pixel_data  in  16  RGB565 colour for the current pixel_index.
- pixel_index  out  13  pixel requested from the source (0..6143, row-major).
- sample_pixel  out  1  one-cycle pulse when pixel_data is latched.
- frame_begin  out  1  one-cycle pulse when pixel 0 starts shifting.
- sending_pixels  out  1  high while in STREAM.
- cs  out  1  SPI chip select, active-low.
- sdin  out  1  SPI data.
- sclk  out  1  SPI clock, idles high.
- d_cn  out  1  0 = command, 1 = data.
- resn  out  1  panel reset, active-low.
- vccen  out  1  panel VCC enable.
- pmoden  out  1  Pmod power enable.

Behaviour:
- Clock and reset: single clock, my_clk_6p25m. Reset is synchronous and active-high (oled_reset). Reset wins over all other activity.
- Reset values: cs=1, sdin=0, sclk=1, d_cn=0, resn=1, vccen=0, pmoden=0, pixel_index=0, sample_pixel=0, frame_begin=0, sending_pixels=0. All counters clear; FSM goes to PWR.
- Reset mid-operation: reset asserted in any state, including mid-byte, restores all reset values on the next edge and restarts power-up. No partial byte is completed.
- FSM states and transitions:
  - PWR: pmoden=1; wait PWR_WAIT cycles; go to RST_LO.
  - RST_LO: resn=0 for RST_CYCLES; go to RST_HI.
  - RST_HI: resn=1; wait RST_CYCLES; go to INIT.
  - INIT: send ROM bytes 0..INIT_LEN-1 with d_cn=0; go to VCC.
  - VCC: vccen=1; wait VCC_WAIT; go to DON.
  - DON: send 0xAF with d_cn=0; go to PRIME.
  - PRIME: 32 cycles with cs=1 and pixel_index=0; pixel_data latched on the last cycle; go to STREAM.
  - STREAM: held indefinitely.
- Command byte frame (INIT, DON): 18 cycles.
  - Cycles 0..15 carry bit 7-(k/2), with cs=0.
  - Even k: sclk=0 and sdin updates. Odd k: sclk=1 (panel samples on the rising edge).
  - Cycles 16..17: cs=1, sclk=1.
- STREAM pixel slot: 32 cycles, same bit timing as a command byte, 16 bits MSB first.
  - cs=0 and d_cn=1 held continuously across slots; no gaps between slots.
- Pixel handshake:
  - At slot cycle 0 of pixel n, pixel_index becomes n+1, wrapping 6143 to 0.
  - At slot cycle 31, pixel_data is latched into the shift register and sample_pixel=1 for that cycle.
  - The source therefore has 31 cycles to present colour; a combinational or registered source is acceptable.
- frame_begin: 1 on slot cycle 0 when the pixel being shifted is index 0, including the first slot after PRIME.
- sending_pixels: 1 from the first STREAM cycle until reset.
- Width rule: pixel_index wraps at 6144, not 8192. A counter value ≥6144 never appears on the port.

Optional Feature:
- Macro: OLED_TEST_PATTERN_EN.
- Defined: the latch ignores pixel_data and uses an internal colour: red = x[6:2], green = y[5:0], blue = 0, where x = index%96 and y = index/96. All timing is unchanged and sample_pixel still pulses.
- Undefined: pixel_data is used, and the pattern logic is absent from the netlist.

Decomposition:
- Package oled_pkg:
  - OLED_W=96, OLED_H=64, OLED_NPIX=6144.
  - CMD_DISPLAY_OFF=8'hAE, CMD_DISPLAY_ON=8'hAF.
  - FSM state enum (PWR, RST_LO, RST_HI, INIT, VCC, DON, PRIME, STREAM).
  - BYTE_CYCLES=18, PIX_CYCLES=32.
- Sub-module oled_init_rom:
  - Combinational, 6-bit address to 8-bit command byte.
  - Byte 0 = 8'hAE, byte 1..2 = 8'hA0, 8'h72 (RGB565 remap).
  - Remaining bytes are the standard SSD1331 contrast, timing and precharge settings.

Test Plan:
- Hold oled_reset 3 cycles → all outputs at their reset values; FSM in PWR.
- PWR_WAIT=10, RST_CYCLES=4, VCC_WAIT=10 → pmoden rises 1 cycle after reset release; resn low exactly 4 cycles; vccen rises after 38×18 INIT cycles; first decoded SPI byte 0xAE with d_cn=0; byte after INIT is 0xAF.
- STREAM with source pixel_data=16'hF81F:
  - Decoded words at sclk rising edges are 0xF81F with d_cn=1.
  - sample_pixel period is 32 cycles.
  - pixel_index leads the shifted pixel by one.
- Run 6145 slots → pixel_index sequence 6142, 6143, 0, 1; frame_begin pulses once per 6144 slots, aligned with pixel 0.
- Assert oled_reset at slot cycle 9 of pixel 100 → next edge cs=1, sclk=1, pmoden=0, sending_pixels=0; full power-up replays.
- With OLED_TEST_PATTERN_EN, index 97 (x=1, y=1) → shifted word 16'h0020.
